// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 memory arbiter slice.
//   - req_id_e    : requester identity, doubles as the bit index into grant vectors
//   - arb_state_e : arbiter FSM state (normal arbitration / host-exclusive lock)
//   - WORD_W      : memory word width
//   - id_to_onehot: maps a requester id to its one-hot grant vector
package mips32_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    REQ_H = 2'd0,
    REQ_D = 2'd1,
    REQ_F = 2'd2
  } req_id_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [2:0] id_to_onehot(input req_id_e id);
    logic [2:0] vec;
    case (id)
      REQ_H:   vec = 3'b001;
      REQ_D:   vec = 3'b010;
      REQ_F:   vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Requester-side bus of the mips32 memory arbiter.
//   h_*  : host/loader port (read/write, plus exclusive lock request)
//   d_*  : MEM-stage data port (read/write)
//   f_*  : IF-stage fetch port (read only)
//   halted   : core halted, fetch requests are ignored
//   *_gnt    : combinational grant in the cycle the command issues
//   *_rvalid : read data valid one cycle after a read grant
//   rdata    : shared read data, qualified by *_rvalid
//   h_locked : host-exclusive lock is active
// Modports: master = requester side, slave = arbiter side.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10
);
  import mips32_pkg::*;

  logic              h_req;
  logic              d_req;
  logic              f_req;
  logic              h_we;
  logic              d_we;
  logic [AW-1:0]     h_addr;
  logic [AW-1:0]     d_addr;
  logic [AW-1:0]     f_addr;
  logic [WORD_W-1:0] h_wdata;
  logic [WORD_W-1:0] d_wdata;
  logic              h_lock;
  logic              halted;
  logic              h_gnt;
  logic              d_gnt;
  logic              f_gnt;
  logic              h_rvalid;
  logic              d_rvalid;
  logic              f_rvalid;
  logic [WORD_W-1:0] rdata;
  logic              h_locked;

  modport master (
    output h_req, d_req, f_req, h_we, d_we, h_addr, d_addr, f_addr,
           h_wdata, d_wdata, h_lock, halted,
    input  h_gnt, d_gnt, f_gnt, h_rvalid, d_rvalid, f_rvalid, rdata, h_locked
  );

  modport slave (
    input  h_req, d_req, f_req, h_we, d_we, h_addr, d_addr, f_addr,
           h_wdata, d_wdata, h_lock, halted,
    output h_gnt, d_gnt, f_gnt, h_rvalid, d_rvalid, f_rvalid, rdata, h_locked
  );

endinterface

// File: rtl/mips32_prio_sel.sv
// Combinational winner selection for the memory arbiter.
//   h_req, d_req : raw requests of host and data ports
//   f_req        : fetch request already qualified by !halted
//   boost        : fetch has been starved long enough to beat the data port
//   locked       : host-exclusive mode, only the host may win
//   en           : low while reset is asserted, suppresses every grant
//   gnt          : one-hot grant vector indexed by req_id_e (all zero when idle)
module mips32_prio_sel
  import mips32_pkg::*;
(
  input  logic       h_req,
  input  logic       d_req,
  input  logic       f_req,
  input  logic       boost,
  input  logic       locked,
  input  logic       en,
  output logic [2:0] gnt
);

  req_id_e win_s;
  logic    vld_s;

  // Fixed priority H > D > F, with a starved fetch promoted above D.
  always_comb begin
    win_s = REQ_H;
    vld_s = 1'b0;
    if (!en) begin
      vld_s = 1'b0;
    end else if (locked) begin
      // D and F stay pending until the lock drops.
      win_s = REQ_H;
      vld_s = h_req;
    end else if (h_req) begin
      win_s = REQ_H;
      vld_s = 1'b1;
    end else if (f_req && boost) begin
      win_s = REQ_F;
      vld_s = 1'b1;
    end else if (d_req) begin
      win_s = REQ_D;
      vld_s = 1'b1;
    end else if (f_req) begin
      win_s = REQ_F;
      vld_s = 1'b1;
    end else begin
      vld_s = 1'b0;
    end
  end

  // Expand the winner into the one-hot grant vector.
  always_comb begin
    if (vld_s) begin
      gnt = id_to_onehot(win_s);
    end else begin
      gnt = 3'b000;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares the single-port unified memory of the mips32 core between the
// host/loader (H), MEM-stage data (D) and IF-stage fetch (F) ports.
// One access per cycle, 1-cycle read latency, host-exclusive lock for
// program loading and an anti-starvation boost for fetch.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   bus          : requester bus (mips32_mem_arbiter_if.slave)
//   mem_en/we    : memory command strobes, mem_addr/mem_wdata command fields
//   mem_rdata    : memory read data, valid the cycle after a read command
//   f_stall_cnt  : saturating count of cycles an eligible fetch was denied
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW         = 10,
  parameter int MAX_STARVE = 4,   // must be >= 1
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  mips32_mem_arbiter_if.slave bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  f_stall_cnt
);

  localparam int SW = (MAX_STARVE < 2) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [CNT_W-1:0] STALL_MAX  = {CNT_W{1'b1}};

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [SW-1:0]     starve_r;
  logic [SW-1:0]     starve_nxt_s;
  logic [CNT_W-1:0]  stall_r;
  logic [CNT_W-1:0]  stall_nxt_s;
  logic [2:0]        rvalid_r;
  logic [2:0]        gnt_s;
  logic              f_act_s;
  logic              boost_s;
  logic              locked_s;
  logic              mem_we_s;
  logic [AW-1:0]     mem_addr_s;
  logic [WORD_W-1:0] mem_wdata_s;

  assign f_act_s  = bus.f_req & ~bus.halted;
  assign boost_s  = (starve_r == STARVE_MAX);
  assign locked_s = (state_r == ST_LOCKED);

  mips32_prio_sel u_prio_sel (
    .h_req  (bus.h_req),
    .d_req  (bus.d_req),
    .f_req  (f_act_s),
    .boost  (boost_s),
    .locked (locked_s),
    .en     (~rst),
    .gnt    (gnt_s)
  );

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Lock FSM: follows h_lock with one cycle of delay in both directions.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (bus.h_lock) begin
          state_nxt_s = ST_LOCKED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LOCKED: begin
        if (!bus.h_lock) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Starve counter: only losses to D count; losses to H or the lock hold it.
  always_comb begin
    starve_nxt_s = starve_r;
    if (!f_act_s || gnt_s[REQ_F]) begin
      starve_nxt_s = {SW{1'b0}};
    end else if (gnt_s[REQ_D] && (starve_r != STARVE_MAX)) begin
      starve_nxt_s = starve_r + SW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Stall statistics: eligible fetch denied this cycle, saturating.
  always_comb begin
    stall_nxt_s = stall_r;
    if (f_act_s && !gnt_s[REQ_F] && (stall_r != STALL_MAX)) begin
      stall_nxt_s = stall_r + CNT_W'(1);
    end else begin
      stall_nxt_s = stall_r;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_r <= {SW{1'b0}};
      stall_r  <= {CNT_W{1'b0}};
    end else begin
      starve_r <= starve_nxt_s;
      stall_r  <= stall_nxt_s;
    end
  end

  // Command mux: the winner drives the memory; fetch is always a read.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = {AW{1'b0}};
    mem_wdata_s = {WORD_W{1'b0}};
    case (gnt_s)
      3'b001: begin
        mem_we_s    = bus.h_we;
        mem_addr_s  = bus.h_addr;
        mem_wdata_s = bus.h_wdata;
      end
      3'b010: begin
        mem_we_s    = bus.d_we;
        mem_addr_s  = bus.d_addr;
        mem_wdata_s = bus.d_wdata;
      end
      3'b100: begin
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.f_addr;
        mem_wdata_s = {WORD_W{1'b0}};
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {WORD_W{1'b0}};
      end
    endcase
  end

  // Read-valid pipe: the granted port sees its data exactly one cycle later,
  // independent of any lock change in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r <= 3'b000;
    end else begin
      rvalid_r <= gnt_s & {3{~mem_we_s}};
    end
  end

  assign mem_en    = |gnt_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;

  assign bus.h_gnt    = gnt_s[REQ_H];
  assign bus.d_gnt    = gnt_s[REQ_D];
  assign bus.f_gnt    = gnt_s[REQ_F];
  assign bus.h_rvalid = rvalid_r[REQ_H];
  assign bus.d_rvalid = rvalid_r[REQ_D];
  assign bus.f_rvalid = rvalid_r[REQ_F];
  assign bus.rdata    = mem_rdata;
  assign bus.h_locked = locked_s;

  assign f_stall_cnt = stall_r;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: directed scenarios plus a
// randomized phase, every cycle compared against a behavioural model.
module tb_mips32_mem_arbiter;
  import mips32_pkg::*;

  localparam int AW         = 10;
  localparam int MAX_STARVE = 4;
  localparam int CNT_W      = 6;
  localparam int STALL_MAX  = (1 << CNT_W) - 1;
  localparam int DEPTH      = 1 << AW;

  logic              clk;
  logic              rst;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  f_stall_cnt;

  mips32_mem_arbiter_if #(.AW(AW)) bus ();

  mips32_mem_arbiter #(.AW(AW), .MAX_STARVE(MAX_STARVE), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .f_stall_cnt (f_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory array environment: single port, 1-cycle read latency.
  logic [31:0] mem [DEPTH];
  bit          mem_written [DEPTH];

  function automatic logic [31:0] init_word(input int a);
    if (a == 100) return 32'd10;
    return 32'(a * 7 + 3);
  endfunction

  function automatic logic [31:0] mem_word(input int a);
    return mem_written[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]         <= mem_wdata;
        mem_written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= mem_word(int'(mem_addr));
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state.
  int          m_lock, m_starve, m_stall, m_rv, last_win;
  logic [31:0] m_rdata;
  logic [31:0] refmem [DEPTH];

  // Observations from the most recent cycle.
  logic [2:0]  obs_gnt, obs_rv;
  logic [31:0] obs_rdata;
  int          obs_stall;

  // One cycle: inputs already driven; compare, advance model at the edge.
  task automatic step();
    int          win;
    bit          we, f_ok, lk;
    logic [AW-1:0] a;
    logic [31:0] wd;
    logic [2:0]  exp_gnt, exp_rv;
    #1;
    if (rst) begin
      m_lock = 0; m_starve = 0; m_stall = 0; m_rv = -1;
    end
    f_ok = bus.f_req && !bus.halted;
    win  = -1;
    if (!rst) begin
      if (m_lock != 0)                          win = bus.h_req ? 0 : -1;
      else if (bus.h_req)                       win = 0;
      else if (f_ok && m_starve == MAX_STARVE)  win = 2;
      else if (bus.d_req)                       win = 1;
      else if (f_ok)                            win = 2;
    end
    we = 1'b0; a = '0; wd = '0;
    if (win == 0) begin we = bus.h_we; a = bus.h_addr; wd = bus.h_wdata; end
    if (win == 1) begin we = bus.d_we; a = bus.d_addr; wd = bus.d_wdata; end
    if (win == 2) begin we = 1'b0;     a = bus.f_addr; end
    exp_gnt = (win >= 0) ? 3'(1 << win) : 3'b000;
    exp_rv  = (m_rv >= 0) ? 3'(1 << m_rv) : 3'b000;
    obs_gnt   = {bus.f_gnt, bus.d_gnt, bus.h_gnt};
    obs_rv    = {bus.f_rvalid, bus.d_rvalid, bus.h_rvalid};
    obs_rdata = bus.rdata;
    obs_stall = int'(f_stall_cnt);
    check_eq("gnt", obs_gnt, exp_gnt);
    check_eq("mem_en", mem_en, (win >= 0));
    if (win >= 0) begin
      check_eq("mem_we", mem_we, we);
      check_eq("mem_addr", mem_addr, a);
      if (we) check_eq("mem_wdata", mem_wdata, wd);
    end
    check_eq("rvalid", obs_rv, exp_rv);
    if (m_rv >= 0) check_eq("rdata", obs_rdata, m_rdata);
    check_eq("h_locked", bus.h_locked, (m_lock != 0));
    check_eq("f_stall_cnt", f_stall_cnt, m_stall);
    lk = bus.h_lock;
    @(posedge clk);
    if (!rst) begin
      if (f_ok && win != 2 && m_stall < STALL_MAX) m_stall++;
      if (!f_ok || win == 2) m_starve = 0;
      else if (win == 1 && m_starve < MAX_STARVE) m_starve++;
      m_rv = -1;
      if (win >= 0 && !we) begin m_rv = win; m_rdata = refmem[a]; end
      if (win >= 0 && we) refmem[a] = wd;
      m_lock = lk ? 1 : 0;
    end
    last_win = win;
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus.h_req = 1'b0; bus.d_req = 1'b0; bus.f_req = 1'b0;
    bus.h_we  = 1'b0; bus.d_we  = 1'b0;
  endtask

  task automatic rand_phase(input int n);
    for (int c = 0; c < n; c++) begin
      if (!bus.h_req || last_win == 0) begin
        bus.h_req   = ($urandom_range(0, 99) < 25);
        bus.h_we    = 1'($urandom_range(0, 1));
        bus.h_addr  = AW'(100 + $urandom_range(0, 7));
        bus.h_wdata = $urandom;
      end
      if (!bus.d_req || last_win == 1) begin
        bus.d_req   = ($urandom_range(0, 99) < 60);
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = AW'(100 + $urandom_range(0, 7));
        bus.d_wdata = $urandom;
      end
      if (!bus.f_req || last_win == 2) begin
        bus.f_req  = ($urandom_range(0, 99) < 60);
        bus.f_addr = AW'(100 + $urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) < 4) bus.h_lock = ~bus.h_lock;
      if ($urandom_range(0, 99) < 4) bus.halted = ~bus.halted;
      step();
    end
  endtask

  initial begin
    int          s0;
    logic [9:0]  pat;
    bit          any_f;
    for (int i = 0; i < DEPTH; i++) begin
      refmem[i]      = init_word(i);
      mem_written[i] = 1'b0;
    end
    m_lock = 0; m_starve = 0; m_stall = 0; m_rv = -1; last_win = -1; m_rdata = '0;
    rst = 1'b1;
    bus.h_req = 1'b1; bus.d_req = 1'b1; bus.f_req = 1'b1;
    bus.h_we = 1'b0; bus.d_we = 1'b0; bus.h_lock = 1'b0; bus.halted = 1'b0;
    bus.h_addr = '0; bus.d_addr = '0; bus.f_addr = '0;
    bus.h_wdata = '0; bus.d_wdata = '0;
    @(negedge clk);

    // Reset: requests pending but nothing granted.
    step();
    step();
    check_eq("rst_no_gnt", obs_gnt, 3'b000);
    rst = 1'b0;
    idle_all();
    step();

    // Host read during RUN.
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = AW'(100);
    step();
    check_eq("hrd_gnt", obs_gnt, 3'b001);
    bus.h_req = 1'b0;
    step();
    check_eq("hrd_rvalid", obs_rv, 3'b001);
    check_eq("hrd_rdata", obs_rdata, 32'd10);

    // Data write then read of the same address.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = AW'(101); bus.d_wdata = 32'd55;
    step();
    bus.d_we = 1'b0;
    step();
    bus.d_req = 1'b0;
    step();
    check_eq("raw_rvalid", obs_rv, 3'b010);
    check_eq("raw_rdata", obs_rdata, 32'd55);

    // Host program load under lock with D/F pending.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(5);
    bus.f_req = 1'b1; bus.f_addr = AW'(6);
    bus.h_lock = 1'b1;
    step();
    for (int i = 0; i <= 16; i++) begin
      bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = AW'(i); bus.h_wdata = 32'hA000 + 32'(i);
      step();
      check_eq("load_gnt", obs_gnt, 3'b001);
    end
    bus.h_req = 1'b0;
    step();
    check_eq("lock_hold", obs_gnt, 3'b000);
    bus.h_lock = 1'b0;
    step();
    step();
    check_eq("unlock_gnt", (obs_gnt == 3'b010 || obs_gnt == 3'b100), 1'b1);
    for (int i = 0; i <= 16; i++) check_eq("image", mem_word(i), 32'hA000 + 32'(i));

    // Starvation boost: D,D,D,D,F repeating.
    idle_all();
    step();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(102);
    bus.f_req = 1'b1; bus.f_addr = AW'(103);
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) s0 = obs_stall;
      pat = {pat[8:0], obs_gnt[2]};
    end
    check_eq("boost_pat", pat, 10'b0000100001);
    step();
    check_eq("boost_stall", obs_stall, (s0 + 8 > STALL_MAX) ? STALL_MAX : s0 + 8);

    // Halt gating: no fetch grants, stall count frozen, D still served.
    bus.halted = 1'b1;
    step();
    s0 = obs_stall;
    any_f = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      any_f |= obs_gnt[2];
    end
    check_eq("halt_no_f", any_f, 1'b0);
    check_eq("halt_stall", obs_stall, s0);
    check_eq("halt_d_gnt", obs_gnt, 3'b010);

    // Stall counter saturation while the host lock keeps F out.
    bus.halted = 1'b0; bus.d_req = 1'b0; bus.h_lock = 1'b1;
    for (int i = 0; i < 70; i++) step();
    check_eq("stall_sat", obs_stall, STALL_MAX);
    bus.h_lock = 1'b0;
    step();
    step();

    // Reset in the cycle after a fetch read grant.
    idle_all();
    step();
    bus.f_req = 1'b1; bus.f_addr = AW'(104);
    step();
    check_eq("mrd_fgnt", obs_gnt, 3'b100);
    bus.f_req = 1'b0;
    rst = 1'b1;
    step();
    check_eq("mrd_rvalid", obs_rv, 3'b000);
    check_eq("mrd_stall", obs_stall, 0);
    rst = 1'b0;
    bus.f_req = 1'b1;
    step();
    check_eq("mrd_resume", obs_gnt, 3'b100);
    bus.f_req = 1'b0;
    step();

    // Randomized traffic against the model.
    rand_phase(500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
